// File: rtl/fp_carpici_pkg.sv
// Shared types for the iterative floating-point multiplier: FSM states,
// operand classes and bit positions inside the 4-bit flag word.
package fp_carpici_pkg;

   typedef enum logic [1:0] {BOS, CARP, NORM, BITTI} durum_e;

   typedef enum logic [2:0] {ZERO, NORMAL, INF, QNAN, SNAN} sinif_e;

   localparam int B_GECERSIZ    = 3;
   localparam int B_TASMA       = 2;
   localparam int B_ALT_TASMA   = 1;
   localparam int B_KESIN_DEGIL = 0;

endpackage

// File: rtl/fp_sinif_coz.sv
// Operand classifier: splits {exp, frac} into class, exponent and significand
// with the hidden one restored. Subnormals are flushed to zero here.
module fp_sinif_coz
   import fp_carpici_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
)(
   input  logic [EXP_W+MAN_W-1:0] alan,
   output sinif_e                 sinif,
   output logic [EXP_W-1:0]       us,
   output logic [MAN_W:0]         sig
);

   logic [EXP_W-1:0] e;
   logic [MAN_W-1:0] f;

   assign e = alan[MAN_W +: EXP_W];
   assign f = alan[MAN_W-1:0];

   always_comb begin
      sinif = NORMAL;
      us    = e;
      sig   = {1'b1, f};
      if (e == '0) begin
         sinif = ZERO;
         us    = '0;
         sig   = '0;
      end else if (e == '1) begin
         sig = '0;
         if (f == '0)          sinif = INF;
         else if (f[MAN_W-1])  sinif = QNAN;
         else                  sinif = SNAN;
      end
   end

endmodule

// File: rtl/fp_carpici_param.sv
// Iterative shift-add floating-point multiplier, BPC multiplier bits per cycle,
// round-to-nearest-even, flush-to-zero, start/hazir/gecerli handshake.
module fp_carpici_param
   import fp_carpici_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BPC   = 1
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   sayi1,
   input  logic [EXP_W+MAN_W:0]   sayi2,
   output logic                   hazir,
   output logic                   gecerli,
   output logic [EXP_W+MAN_W:0]   sonuc,
   output logic [3:0]             bayrak
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 1;
   localparam int PW    = 2 * SIG_W;
   localparam int K     = SIG_W / BPC;
   localparam int EW2   = EXP_W + 2;
   localparam int CW    = $clog2(K + 1);
   localparam int RW    = MAN_W + 1;
   localparam logic [EW2-1:0] BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW2-1:0] E_MAX   = EW2'((1 << EXP_W) - 1);
   localparam logic [W-1:0]   CNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [W-2:0]   INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

   if (SIG_W % BPC != 0) begin : g_bpc_chk
      $error("BPC must divide MAN_W+1");
   end

   sinif_e             c1, c2;
   logic [EXP_W-1:0]   us1, us2;
   logic [MAN_W:0]     sig1, sig2;

   fp_sinif_coz #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_coz1 (
      .alan (sayi1[W-2:0]),
      .sinif(c1),
      .us   (us1),
      .sig  (sig1)
   );

   fp_sinif_coz #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_coz2 (
      .alan (sayi2[W-2:0]),
      .sinif(c2),
      .us   (us2),
      .sig  (sig2)
   );

   durum_e           durum;
   logic [PW-1:0]    a_sh, acc, pp;
   logic [SIG_W-1:0] b_sh;
   logic [CW-1:0]    cnt;
   logic [EW2-1:0]   e_sum;
   logic             isaret;

   // Special-operand resolution straight from the input operands
   logic             s, ozel;
   logic [W-1:0]     ozel_sonuc;
   logic [3:0]       ozel_bayrak;

   always_comb begin
      s           = sayi1[W-1] ^ sayi2[W-1];
      ozel        = 1'b1;
      ozel_sonuc  = '0;
      ozel_bayrak = '0;
      if (c1 inside {QNAN, SNAN} || c2 inside {QNAN, SNAN}) begin
         ozel_sonuc              = CNAN;
         ozel_bayrak[B_GECERSIZ] = (c1 == SNAN) || (c2 == SNAN);
      end else if ((c1 == INF && c2 == ZERO) || (c1 == ZERO && c2 == INF)) begin
         ozel_sonuc              = CNAN;
         ozel_bayrak[B_GECERSIZ] = 1'b1;
      end else if (c1 == INF || c2 == INF) begin
         ozel_sonuc = {s, INF_MAG};
      end else if (c1 == ZERO || c2 == ZERO) begin
         ozel_sonuc = {s, {(W-1){1'b0}}};
      end else begin
         ozel = 1'b0;
      end
   end

   assign pp = a_sh * PW'(b_sh[BPC-1:0]);

   // norm drops the leading one, so its top MAN_W bits are the fraction
   logic [PW-2:0]    norm;
   logic [MAN_W-1:0] kes;
   logic [RW-1:0]    kes_r;
   logic             guard, sticky, r_inc;
   logic [EW2-1:0]   e_n, e_r;
   logic [W-1:0]     n_sonuc;
   logic [3:0]       n_bayrak;

   always_comb begin
      norm   = acc[PW-1] ? acc[PW-2:0] : {acc[PW-3:0], 1'b0};
      kes    = norm[PW-2:MAN_W+1];
      guard  = norm[MAN_W];
      sticky = |norm[MAN_W-1:0];
      e_n    = e_sum + EW2'(acc[PW-1]);
      r_inc  = guard & (sticky | kes[0]);
      kes_r  = {1'b0, kes} + RW'(r_inc);
      e_r    = e_n + EW2'(kes_r[MAN_W]);
      n_sonuc  = {isaret, e_r[EXP_W-1:0], kes_r[MAN_W-1:0]};
      n_bayrak = '0;
      n_bayrak[B_KESIN_DEGIL] = guard | sticky;
      if (e_n[EW2-1] || e_n == '0) begin
         n_sonuc                 = {isaret, {(W-1){1'b0}}};
         n_bayrak[B_ALT_TASMA]   = 1'b1;
         n_bayrak[B_KESIN_DEGIL] = 1'b1;
      end else if (e_r >= E_MAX) begin
         n_sonuc                 = {isaret, INF_MAG};
         n_bayrak[B_TASMA]       = 1'b1;
         n_bayrak[B_KESIN_DEGIL] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         durum   <= BOS;
         hazir   <= 1'b1;
         gecerli <= 1'b0;
         sonuc   <= '0;
         bayrak  <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         acc     <= '0;
         cnt     <= '0;
         e_sum   <= '0;
         isaret  <= 1'b0;
      end else begin
         gecerli <= 1'b0;
         case (durum)
            BOS: if (start) begin
               hazir  <= 1'b0;
               isaret <= s;
               a_sh   <= PW'(sig1);
               b_sh   <= sig2;
               acc    <= '0;
               cnt    <= '0;
               e_sum  <= EW2'(us1) + EW2'(us2) - BIAS;
               if (ozel) begin
                  sonuc   <= ozel_sonuc;
                  bayrak  <= ozel_bayrak;
                  gecerli <= 1'b1;
                  durum   <= BITTI;
               end else begin
                  durum <= CARP;
               end
            end
            CARP: begin
               acc  <= acc + pp;
               a_sh <= a_sh << BPC;
               b_sh <= b_sh >> BPC;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(K - 1)) durum <= NORM;
            end
            NORM: begin
               sonuc   <= n_sonuc;
               bayrak  <= n_bayrak;
               gecerli <= 1'b1;
               durum   <= BITTI;
            end
            BITTI: begin
               hazir <= 1'b1;
               durum <= BOS;
            end
            default: durum <= BOS;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_carpici_param.sv
// Directed bench: three multiplier instances (defaults, BPC=4, half precision)
// driven one at a time and compared against hand-computed results.
module tb_fp_carpici_param;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        hz0, hz1, hz2, gv0, gv1, gv2;
   logic [31:0] s0, s1;
   logic [15:0] s2;
   logic [3:0]  f0, f1, f2;

   always #5 clk = ~clk;

   fp_carpici_param u0 (
      .clk(clk), .reset_n(reset_n), .start(st0), .sayi1(a), .sayi2(b),
      .hazir(hz0), .gecerli(gv0), .sonuc(s0), .bayrak(f0));

   fp_carpici_param #(.BPC(4)) u1 (
      .clk(clk), .reset_n(reset_n), .start(st1), .sayi1(a), .sayi2(b),
      .hazir(hz1), .gecerli(gv1), .sonuc(s1), .bayrak(f1));

   fp_carpici_param #(.EXP_W(5), .MAN_W(10), .BPC(1)) u2 (
      .clk(clk), .reset_n(reset_n), .start(st2), .sayi1(a[15:0]), .sayi2(b[15:0]),
      .hazir(hz2), .gecerli(gv2), .sonuc(s2), .bayrak(f2));

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic hz(input int sel);
      return (sel == 0) ? hz0 : (sel == 1) ? hz1 : hz2;
   endfunction

   function automatic logic gv(input int sel);
      return (sel == 0) ? gv0 : (sel == 1) ? gv1 : gv2;
   endfunction

   function automatic logic [31:0] res(input int sel);
      return (sel == 0) ? s0 : (sel == 1) ? s1 : {16'h0, s2};
   endfunction

   function automatic logic [3:0] flg(input int sel);
      return (sel == 0) ? f0 : (sel == 1) ? f1 : f2;
   endfunction

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0:       st0 = v;
         1:       st1 = v;
         default: st2 = v;
      endcase
   endtask

   // lat counts edges from the accepting edge up to the one raising gecerli
   task automatic run(input string tag, input int sel, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] r, input logic [3:0] fl, input int lat_exp, input bit poke);
      int lat;
      @(negedge clk);
      chk({tag, " hazir"}, 32'(hz(sel)), 32'd1);
      a = x;
      b = y;
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      lat = 1;
      while (!gv(sel) && lat < 100) begin
         if (poke && lat == 5) begin
            a = 32'h3F800000;
            b = 32'h3F800000;
            set_start(sel, 1'b1);
         end else begin
            set_start(sel, 1'b0);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      set_start(sel, 1'b0);
      chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
      chk({tag, " sonuc"}, res(sel), r);
      chk({tag, " bayrak"}, 32'(flg(sel)), 32'(fl));
      @(posedge clk);
      #1;
      chk({tag, " pulse"}, 32'(gv(sel)), 32'd0);
      chk({tag, " hazir after"}, 32'(hz(sel)), 32'd1);
   endtask

   initial begin
      bit seen;
      repeat (2) @(posedge clk);
      #1;
      chk("reset hazir", 32'(hz0), 32'd1);
      chk("reset gecerli", 32'(gv0), 32'd0);
      chk("reset sonuc", s0, 32'h0);
      chk("reset bayrak", 32'(f0), 32'h0);
      reset_n = 1'b1;

      run("mul 1.5x2",    0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, 1'b0);
      run("round",        0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26, 1'b0);
      run("sign",         0, 32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000, 26, 1'b0);
      run("inf x 0",      0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1,  1'b0);
      run("snan",         0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1,  1'b0);
      run("qnan",         0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 1,  1'b0);
      run("subnormal",    0, 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1,  1'b0);
      run("overflow",     0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 26, 1'b0);
      run("underflow",    0, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 26, 1'b0);
      run("neg underflow",0, 32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 26, 1'b0);
      run("start ignored",0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, 1'b1);

      // Abort an operation with reset at cycle 10
      @(negedge clk);
      a = 32'h3F800001;
      b = 32'h3F800001;
      st0 = 1'b1;
      @(posedge clk);
      #1;
      st0 = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("midrst hazir", 32'(hz0), 32'd1);
      chk("midrst sonuc", s0, 32'h0);
      chk("midrst bayrak", 32'(f0), 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (gv0) seen = 1'b1;
      end
      chk("midrst no gecerli", 32'(seen), 32'd0);

      run("after reset",  0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, 1'b0);
      run("half 1x2",     2, 32'h00003C00, 32'h00004000, 32'h00004000, 4'b0000, 13, 1'b0);
      run("bpc4 1.5x2",   1, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 8,  1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/fp_carpici_param.md
Name: fp_carpici_param

Overview:
Parametrised, iterative IEEE-754-style floating-point multiplier. It generalises the single-precision shift-add multiplier to any exponent and mantissa width and to a configurable number of multiplier bits retired per cycle. It adds a start/ready/valid handshake, round-to-nearest-even, and exception flags.
It sits in the arithmetic datapath as a drop-in multi-cycle multiplier.

Parameters:
EXP_W, 8, exponent field width (>=3).
MAN_W, 23, stored fraction width (>=2); significand is MAN_W+1 bits including the hidden 1.
BPC, 1, multiplier bits retired per CARP cycle; must divide MAN_W+1 (elaboration error otherwise).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  synchronous, active-low reset.
start  in  1  request; sampled only when hazir=1.
sayi1  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}.
sayi2  in  1+EXP_W+MAN_W  operand B.
hazir  out  1  block idle, will accept start.
gecerli  out  1  one-cycle pulse, sonuc/bayrak valid.
sonuc  out  1+EXP_W+MAN_W  result; held until the next accepted start.
bayrak  out  4  {gecersiz, tasma, alt_tasma, kesin_degil}; held with sonuc.

Behaviour:
- Reset (reset_n=0 at an edge): state BOS, hazir=1, gecerli=0, sonuc=0, bayrak=0, all internal accumulators cleared. This applies mid-operation too; the in-flight operation is dropped and produces no gecerli.
- BIAS=2^(EXP_W-1)-1; K=(MAN_W+1)/BPC.
- FSM BOS -> CARP -> NORM -> BITTI -> BOS.
- BOS: hazir=1. On start, latch operands, decode classes, compute sign = s1^s2, go to CARP. If the operation is special, go straight to BITTI with the result preloaded.
- CARP: K cycles; each cycle adds sig1 * (next BPC bits of sig2, LSB first) << position into a 2*(MAN_W+1)-bit accumulator.
- NORM: 1 cycle; normalise, round, and apply exponent checks.
- BITTI: gecerli=1 for exactly one cycle, sonuc/bayrak registered, then return to BOS. hazir=1 again in the cycle after gecerli.
- Latency (start edge to gecerli high): normal = K+2 cycles (26 at defaults); special = 1 cycle.
- start while hazir=0 is ignored.
- start in the BITTI cycle is ignored; hazir is 0 there.
- Class decode: subnormal inputs are flushed to zero (sign kept) before any other check.
- NaN: exp all ones and frac != 0. sNaN is a NaN with frac MSB 0.
- Canonical NaN: sign 0, exp all ones, frac = 1 followed by zeros. At defaults this is 7FC00000.
- Special-case priority:
  1. Any NaN operand -> canonical NaN; gecersiz=1 only for an sNaN operand.
  2. Inf*0 or 0*Inf -> canonical NaN, gecersiz=1.
  3. Inf * non-zero -> signed Inf.
  4. 0 * finite -> signed zero, no flags.
- Normal path, exponent math: done in signed EXP_W+2 bits, E = e1+e2-BIAS.
- Normalisation: if product MSB=1, E+=1 and take frac from the bits below the MSB. Otherwise take frac one bit lower. Guard is the next bit; sticky is the OR of the remainder.
- Rounding: RNE, increment when guard & (sticky | lsb). A carry out of the fraction gives frac=0, E+=1. kesin_degil = guard|sticky.
- Overflow (E >= 2^EXP_W-1 after rounding) -> signed Inf, tasma=1, kesin_degil=1.
- Underflow (E <= 0, checked before rounding) -> signed zero, alt_tasma=1, kesin_degil=1. No subnormal outputs are produced.

Decomposition:
- Package fp_carpici_pkg: state enum (BOS, CARP, NORM, BITTI), operand class enum (ZERO, NORMAL, INF, QNAN, SNAN), flag bit index constants.
- Width-dependent constants (BIAS, K, canonical NaN) are localparams in the module.
- One sub-module fp_sinif_coz (parametrised by EXP_W, MAN_W) classifies an operand. It is instantiated twice.

Test Plan:
1. Defaults: 3FC00000 * 40000000 -> sonuc 40400000, bayrak 0, gecerli exactly 26 cycles after start, one-cycle pulse.
2. Rounding: 3F800001 * 3F800001 -> 3F800002, kesin_degil=1. Sign check: BF800000 * 3F800000 -> BF800000, bayrak 0.
3. Specials:
   - 7F800000 * 00000000 -> 7FC00000 with gecersiz=1, latency 1.
   - 7F800001 * 3F800000 -> 7FC00000 with gecersiz=1.
   - 7FC00000 * 3F800000 -> 7FC00000 with gecersiz=0.
   - 00000001 (subnormal) * 3F800000 -> 00000000.
4. Range:
   - 7F000000 * 7F000000 -> 7F800000, tasma=1, kesin_degil=1.
   - 00800000 * 3F000000 -> 00000000, alt_tasma=1, kesin_degil=1.
   - 80800000 * 3F000000 -> 80000000.
5. Handshake/reset:
   - start pulsed again mid-CARP -> ignored, first result unchanged.
   - reset_n=0 at cycle 10 of an operation -> next cycle hazir=1, sonuc=0, no gecerli.
   - New operation afterwards -> correct result.
6. Params:
   - EXP_W=5, MAN_W=10, BPC=1: 3C00 * 4000 -> 4000, latency 13.
   - Defaults with BPC=4: 3FC00000 * 40000000 -> 40400000, latency 8.
